load_store_unit: RTL

Multi-cycle data-memory responder for the RISC-V core. It accepts load/store requests (ALU address, store data from register read port 2, funct3, write flag) over a valid/ready handshake. It performs byte/half/word accesses on an internal word-organised, little-endian memory and returns loads sign- or zero-extended, ready for the register-file write-back `result` path. It sits opposite the decode/register-file block: it consumes what that block produces on `rd2`/`MemWrite` and produces what that block consumes as write-back data.

---
 rtl/load_store_unit_if.sv | 26 ++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/response bus between the core and the data-memory load/store unit.
// The master side issues loads/stores; the slave side answers with one response per request.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic                  busy;

  modport master (
    output req_valid, req_write, funct3, addr, wdata,
    input  req_ready, resp_valid, rdata, err, busy
  );

  modport slave (
    input  req_valid, req_write, funct3, addr, wdata,
    output req_ready, resp_valid, rdata, err, busy
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle byte/half/word data-memory responder on a word-organised little-endian RAM.
// Loads come back sign/zero-extended, ready for register write-back.
module load_store_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 10,
  parameter int LATENCY       = 2
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MEM_WORDS = 2 ** MEM_ADDR_BITS;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic                    write_q;
  logic [2:0]              funct3_q;
  logic [MEM_ADDR_BITS+1:0] addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                     accept;
  logic                     enter_resp;
  logic [MEM_ADDR_BITS-1:0] word_idx;
  logic [1:0]               lane;
  logic                     access_err;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic [7:0]               rd_byte;
  logic [15:0]              rd_half;
  logic [DATA_WIDTH-1:0]    load_val;
  logic                     unused_addr_bits;

  assign accept     = (state_q == IDLE) && bus.req_valid;
  assign enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);
  assign word_idx   = addr_q[MEM_ADDR_BITS+1:2];
  assign lane       = addr_q[1:0];

  // Upper address bits are intentionally dropped so accesses wrap modulo memory size.
  assign unused_addr_bits = ^bus.addr[DATA_WIDTH-1:MEM_ADDR_BITS+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      write_q  <= bus.req_write;
      funct3_q <= bus.funct3;
      addr_q   <= bus.addr[MEM_ADDR_BITS+1:0];
      wdata_q  <= bus.wdata;
    end
  end

  // Misalignment and illegal encodings both suppress the memory access.
  always_comb begin
    access_err = 1'b0;
    case (funct3_q)
      3'b000:  access_err = 1'b0;
      3'b001:  access_err = addr_q[0];
      3'b010:  access_err = |addr_q[1:0];
      3'b100:  access_err = write_q;
      3'b101:  access_err = write_q | addr_q[0];
      default: access_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_word  = mem[word_idx];
    rd_byte  = rd_word[{lane, 3'b000} +: 8];
    rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = '0;
    case (funct3_q)
      3'b000:  load_val = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
      3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, rd_half};
      default: load_val = '0;
    endcase
  end

  // A reset landing on the RESP-entry edge must drop the pending store.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && write_q && !access_err) begin
      case (funct3_q[1:0])
        2'b00:   mem[word_idx][{lane, 3'b000} +: 8]       <= wdata_q[7:0];
        2'b01:   mem[word_idx][{addr_q[1], 4'b0000} +: 16] <= wdata_q[15:0];
        default: mem[word_idx]                             <= wdata_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      rdata_q <= (write_q || access_err) ? '0 : load_val;
      err_q   <= access_err;
    end else begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;

endmodule
